// File: rtl/mux12_rr_arbiter_pkg.sv
// Shared constants, state encoding and index helper for the 12-way round-robin arbiter.
package mux12_rr_arbiter_pkg;

    localparam int unsigned NUM_IN = 12;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Increment a source index, wrapping 11 back to 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(NUM_IN - 1)) ? '0 : idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux12.sv
// 12:1 operand mux: select 0-7 addresses the 8-wide group, 8-11 the auxiliary inputs.
module mux12 #(
    parameter int unsigned W = 8
) (
    input  logic [8*W-1:0] in0_7,
    input  logic [W-1:0]   in8,
    input  logic [W-1:0]   in9,
    input  logic [W-1:0]   in10,
    input  logic [W-1:0]   in11,
    input  logic [3:0]     sel,
    output logic [W-1:0]   out
);

    // Group select on bit 3, then low bits pick within the group.
    always_comb begin
        out = '0;
        if (!sel[3]) begin
            out = in0_7[32'(sel[2:0])*W +: W];
        end else begin
            case (sel[1:0])
                2'd0:    out = in8;
                2'd1:    out = in9;
                2'd2:    out = in10;
                default: out = in11;
            endcase
        end
    end

endmodule

// File: rtl/mux12_rr_arbiter_rr_pick12.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod 12.
module rr_pick12
    import mux12_rr_arbiter_pkg::*;
(
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    // Scan ptr, ptr+1, ... 11, 0, ... ptr-1 and keep the first hit.
    always_comb begin
        int unsigned pos;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            if (!any && req[SEL_W'(pos)]) begin
                any = 1'b1;
                idx = SEL_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mux12_rr_arbiter.sv
// Round-robin arbiter/sequencer for the PE's 12:1 operand mux with a registered valid/ready output stage.
module mux12_rr_arbiter
    import mux12_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN-1:0]           in_last,
    input  logic [NUM_IN*DATA_SIZE-1:0] in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_src,
    output logic                        busy
);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic [DATA_SIZE-1:0] sel_data;
    logic              sel_last;
    logic              sel_valid;
    logic              out_free;
    logic              xfer;

    rr_pick12 u_pick (
        .req (in_valid),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    mux12 #(.W(DATA_SIZE)) u_mux_data (
        .in0_7 (in_data[8*DATA_SIZE-1:0]),
        .in8   (in_data[8*DATA_SIZE +: DATA_SIZE]),
        .in9   (in_data[9*DATA_SIZE +: DATA_SIZE]),
        .in10  (in_data[10*DATA_SIZE +: DATA_SIZE]),
        .in11  (in_data[11*DATA_SIZE +: DATA_SIZE]),
        .sel   (grant),
        .out   (sel_data)
    );

    mux12 #(.W(1)) u_mux_last (
        .in0_7 (in_last[7:0]),
        .in8   (in_last[8]),
        .in9   (in_last[9]),
        .in10  (in_last[10]),
        .in11  (in_last[11]),
        .sel   (grant),
        .out   (sel_last)
    );

    mux12 #(.W(1)) u_mux_valid (
        .in0_7 (in_valid[7:0]),
        .in8   (in_valid[8]),
        .in9   (in_valid[9]),
        .in10  (in_valid[10]),
        .in11  (in_valid[11]),
        .sel   (grant),
        .out   (sel_valid)
    );

    assign busy     = (state == BUSY);
    assign out_free = !out_valid || out_ready;
    assign xfer     = busy && sel_valid && out_free;

    // Only the granted source may see ready, and only when the output stage can take a beat.
    always_comb begin
        in_ready = '0;
        if (busy) begin
            in_ready[grant] = out_free;
        end
    end

    // Arbitration FSM: pick in IDLE, hold the grant until a last beat is transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer && sel_last) begin
                        ptr   <= next_idx(grant);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on transfer, drop valid once downstream accepts without a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
